// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller: one digit per slot, blanked dead time
// at the start of every slot, and shadow data swapped only at frame boundaries.
module ssd_scan_ctrl #(
  parameter int CLK_DIV     = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic        x1,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  en,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [3:0]  anodes,
  output logic [7:0]  SSD
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadowVal;
  logic [3:0]    r_shadowDp;
  logic [3:0]    r_shadowEn;
  logic          r_loadPending;
  logic [3:0]    r_anodes;
  logic [7:0]    r_ssd;
  logic          r_loadAck;
  logic          r_frameTick;

  logic          w_slotEnd;
  logic          w_frameEnd;
  logic          w_capture;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg;
  logic [3:0]    w_anodesNext;
  logic [7:0]    w_ssdNext;

  assign w_slotEnd  = (r_cnt == LAST_CNT);
  assign w_frameEnd = w_slotEnd && (r_idx == 2'd3);
  assign w_capture  = w_frameEnd && (r_loadPending || load);
  assign w_nibble   = r_shadowVal[{r_idx, 2'b00} +: 4];

  always_ff @(posedge x1 or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_slotEnd) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge x1 or posedge reset) begin
    if (reset) begin
      r_state <= BLANK;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // The state mirrors the slot phase: BLANK for the first DEAD_CYCLES counts, then DRIVE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      BLANK: if (r_cnt == DEAD_LAST) w_stateNext = DRIVE;
      DRIVE: if (w_slotEnd) w_stateNext = BLANK;
      default: w_stateNext = BLANK;
    endcase
  end

  always_comb begin
    w_seg = 7'h7F;
    case (w_nibble)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  // Segments follow the digit even when its anode is masked, so a disabled digit
  // only loses its anode while still occupying its full slot.
  always_comb begin
    w_anodesNext = 4'hF;
    w_ssdNext    = 8'hFF;
    if (r_state == DRIVE) begin
      w_anodesNext = r_shadowEn[r_idx] ? ~(4'b0001 << r_idx) : 4'hF;
      w_ssdNext    = {~r_shadowDp[r_idx], w_seg};
    end
  end

  always_ff @(posedge x1 or posedge reset) begin
    if (reset) begin
      r_anodes    <= 4'hF;
      r_ssd       <= 8'hFF;
      r_frameTick <= 1'b0;
      r_loadAck   <= 1'b0;
    end else begin
      r_anodes    <= w_anodesNext;
      r_ssd       <= w_ssdNext;
      r_frameTick <= w_frameEnd;
      r_loadAck   <= w_capture;
    end
  end

  // A load seen on the boundary cycle itself is captured directly, so it must not
  // leave the pending flag set for the following frame.
  always_ff @(posedge x1 or posedge reset) begin
    if (reset) begin
      r_shadowVal   <= 16'h0000;
      r_shadowDp    <= 4'h0;
      r_shadowEn    <= 4'h0;
      r_loadPending <= 1'b0;
    end else if (w_capture) begin
      r_shadowVal   <= value;
      r_shadowDp    <= dp;
      r_shadowEn    <= en;
      r_loadPending <= 1'b0;
    end else if (load) begin
      r_loadPending <= 1'b1;
    end
  end

  assign anodes     = r_anodes;
  assign SSD        = r_ssd;
  assign load_ack   = r_loadAck;
  assign frame_tick = r_frameTick;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: a cycle-count reference model pushes the
// expected outputs of every clock edge; a negedge monitor pops and compares them.
module tb_ssd_scan_ctrl;

  localparam int CLK_DIV = 8;
  localparam int DEAD    = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic        x1 = 1'b0;
  logic        reset;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  en = 4'h0;
  logic        load = 1'b0;
  logic        load_ack;
  logic        frame_tick;
  logic [3:0]  anodes;
  logic [7:0]  SSD;

  ssd_scan_ctrl #(.CLK_DIV(CLK_DIV), .DEAD_CYCLES(DEAD)) dut (
    .x1(x1), .reset(reset), .value(value), .dp(dp), .en(en), .load(load),
    .load_ack(load_ack), .frame_tick(frame_tick), .anodes(anodes), .SSD(SSD)
  );

  always #5 x1 = ~x1;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] ssd;
    logic       ack;
    logic       tick;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   checks = 0;
  int   failures = 0;
  int   pushes = 0;
  int   pops = 0;

  logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: k counts edges since reset release; slot phase and digit are
  // plain arithmetic on k, and the shadow copy is swapped on every 32nd edge.
  int          k = 0;
  logic [15:0] mVal = 16'h0;
  logic [3:0]  mDp = 4'h0;
  logic [3:0]  mEn = 4'h0;
  bit          mPend = 1'b0;

  task automatic modelStep(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                           input logic l, input logic rst, output exp_t x);
    int pos;
    int slot;
    x.an = 4'hF; x.ssd = 8'hFF; x.ack = 1'b0; x.tick = 1'b0;
    if (rst) begin
      k = 0; mVal = 16'h0; mDp = 4'h0; mEn = 4'h0; mPend = 1'b0;
      return;
    end
    pos  = k % CLK_DIV;
    slot = (k / CLK_DIV) % 4;
    if (pos >= DEAD) begin
      for (int i = 0; i < 4; i++) x.an[i] = !(i == slot && mEn[slot]);
      x.ssd = {~mDp[slot], segTab[mVal[slot*4 +: 4]]};
    end
    if (k % FRAME == FRAME - 1) begin
      x.tick = 1'b1;
      if (mPend || l) begin
        x.ack = 1'b1;
        mVal = v; mDp = d; mEn = e; mPend = 1'b0;
      end
    end else if (l) begin
      mPend = 1'b1;
    end
    k++;
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d,
                               input logic [3:0] e, input logic l);
    exp_t x;
    value = v; dp = d; en = e; load = l;
    modelStep(v, d, e, l, reset, x);
    @(posedge x1);
    expQ.push_back(x);
    pushes++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(value, dp, en, 1'b0);
  endtask

  task automatic idleUntil(input int framePos);
    for (int i = 0; i < FRAME && (k % FRAME) != framePos; i++) applyStimulus(value, dp, en, 1'b0);
  endtask

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge x1);
      if (expQ.size() > 0) begin
        monExp = expQ.pop_front();
        pops++;
        checkOutput("anodes", int'(anodes), int'(monExp.an));
        checkOutput("SSD", int'(SSD), int'(monExp.ssd));
        checkOutput("load_ack", int'(load_ack), int'(monExp.ack));
        checkOutput("frame_tick", int'(frame_tick), int'(monExp.tick));
        checkOutput("oneAnodeLow", int'($countones(~anodes) <= 1), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (3) applyStimulus(16'h0, 4'h0, 4'h0, 1'b0);
    reset = 1'b0;

    // Dark display after reset, ticks only.
    idle(3 * FRAME);

    // Basic scan: 8A10 loaded mid-frame, shown from the next frame on.
    idle(5);
    applyStimulus(16'h8A10, 4'b0001, 4'hF, 1'b1);
    idle(2 * FRAME);

    // No tearing: new value requested during slot 1.
    idleUntil(CLK_DIV + 2);
    applyStimulus(16'h1234, 4'b0001, 4'hF, 1'b1);
    applyStimulus(16'hFFFF, 4'b1111, 4'h0, 1'b0);
    idle(2 * FRAME);

    // Enable mask.
    applyStimulus(16'h5A5A, 4'b0000, 4'b1010, 1'b1);
    idle(2 * FRAME);

    // Load asserted exactly on the boundary cycle.
    idleUntil(FRAME - 1);
    applyStimulus(16'hC3E7, 4'b0110, 4'b1101, 1'b1);
    idle(FRAME + 4);

    // Load held high with inputs changing every cycle.
    for (int i = 0; i < 3 * FRAME; i++)
      applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), 1'b1);

    // Random inputs with sparse load pulses.
    for (int i = 0; i < 12 * FRAME; i++)
      applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));

    // Reset in a DRIVE cycle with a load pending.
    applyStimulus(16'hC0DE, 4'b0101, 4'hF, 1'b1);
    idle(FRAME);
    idleUntil(1);
    applyStimulus(16'hBEEF, 4'hF, 4'hF, 1'b1);
    idleUntil(5);
    #6 reset = 1'b1;
    #1;
    checkOutput("asyncResetAnodes", int'(anodes), 'hF);
    checkOutput("asyncResetSSD", int'(SSD), 'hFF);
    checkOutput("asyncResetAck", int'(load_ack), 0);
    repeat (3) applyStimulus(16'hBEEF, 4'hF, 4'hF, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++)
      applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), 1'b0);

    @(negedge x1);
    #1;
    checkOutput("scoreboardDrained", expQ.size(), 0);
    checkOutput("popCount", pops, pushes);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
